// File: rtl/counter_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_cmd_sequencer
// Description : Queues LOAD/UP/DOWN/HOLD commands in a small FIFO and plays
//               them out as load/enable/up_down strobes for a counter.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int RPT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_data,
    input  logic [RPT_W-1:0]         cmd_rpt,
    output logic [WIDTH-1:0]         data_in,
    output logic                     load,
    output logic                     enable,
    output logic                     up_down,
    output logic                     busy,
    output logic                     done_pulse,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = $clog2(DEPTH) + 1;
    localparam logic [c_cw-1:0]  c_depth    = c_cw'(DEPTH);
    localparam logic [c_aw-1:0]  c_last_idx = c_aw'(DEPTH - 1);
    localparam logic [1:0]       c_op_load  = 2'b00;
    localparam logic [1:0]       c_op_up    = 2'b01;
    localparam logic [1:0]       c_op_down  = 2'b10;
    localparam logic [1:0]       c_op_hold  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_mem_op   [DEPTH];
    logic [WIDTH-1:0]   r_mem_data [DEPTH];
    logic [RPT_W-1:0]   r_mem_rpt  [DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_cw-1:0]    r_count;

    logic [1:0]         r_op;
    logic [RPT_W-1:0]   r_rem;
    logic [WIDTH-1:0]   r_data_in;

    logic               w_push;
    logic               w_pop;
    logic               w_last;
    logic               w_fifo_empty;
    logic [1:0]         w_head_op;
    logic [WIDTH-1:0]   w_head_data;
    logic [RPT_W-1:0]   w_head_rpt;
    logic [RPT_W-1:0]   w_head_len;

    // Readiness comes from registered occupancy only, so a pop never frees a slot in the same cycle.
    assign cmd_ready    = (r_count < c_depth) & ~reset;
    assign w_push       = cmd_valid & cmd_ready;
    assign w_fifo_empty = (r_count == '0);

    assign w_head_op    = r_mem_op[r_rd_ptr];
    assign w_head_data  = r_mem_data[r_rd_ptr];
    assign w_head_rpt   = r_mem_rpt[r_rd_ptr];
    assign w_head_len   = ((w_head_op == c_op_load) || (w_head_rpt == '0)) ? RPT_W'(1) : w_head_rpt;

    assign w_last       = (r_state == ST_EXEC) && (r_rem == RPT_W'(1));
    assign w_pop        = !w_fifo_empty && ((r_state == ST_IDLE) || w_last);

    assign busy         = (r_state == ST_EXEC) | !w_fifo_empty;
    assign fifo_count   = r_count;
    assign data_in      = r_data_in;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr]   <= cmd_op;
            r_mem_data[r_wr_ptr] <= cmd_data;
            r_mem_rpt[r_wr_ptr]  <= cmd_rpt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_op      <= c_op_hold;
            r_rem     <= '0;
            r_data_in <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_idx) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_idx) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A pop reloads the command registers; otherwise count down, saturating at zero.
            if (w_pop) begin
                r_op  <= w_head_op;
                r_rem <= w_head_len;
                if (w_head_op == c_op_load) begin
                    r_data_in <= w_head_data;
                end
            end else if ((r_state == ST_EXEC) && (r_rem != '0)) begin
                r_rem <= r_rem - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        load        = 1'b0;
        enable      = 1'b0;
        up_down     = 1'b0;
        done_pulse  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                load       = (r_op == c_op_load);
                enable     = (r_op == c_op_up) || (r_op == c_op_down);
                up_down    = (r_op == c_op_up);
                done_pulse = w_last;
                if (w_last && w_fifo_empty) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
